mode_scheduler: RTL

MODE_SCHEDULER -- requirements
Module: mode_scheduler

---
 rtl/mode_scheduler_if.sv | 24 ++
 rtl/mode_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mode_scheduler_if.sv
// Avalon-MM slave bus for the mode scheduler register file.
interface mode_scheduler_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/mode_scheduler.sv
// Mode scheduler: drives an actuator between OFF and ON either from a
// software bit or from an automatic ON/OFF duty pattern, with a minimum
// dwell (hold) after every change of mode.
//
// state     | meaning
// ----------+------------------------------------------------------------
// DISABLED  | EN=0; out_port low, hold and phase counters parked at 0
// OFF       | enabled, actuator off; phase counts ticks spent in OFF
// ON        | enabled, actuator on;  phase counts ticks spent in ON
module mode_scheduler #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  mode_scheduler_if.slave   bus,
  output logic              out_port
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_OFF      = 2'd1,
    ST_ON       = 2'd2
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic        wr_en;
  logic        ctrl_en;
  logic        ctrl_src;
  logic        ctrl_sw;
  logic [15:0] hold_cfg;
  logic [15:0] on_ticks;
  logic [15:0] off_ticks;

  logic [15:0] presc_cnt;
  logic        tick;

  state_t      state;
  state_t      state_next;
  logic [15:0] hold_cnt;
  logic [15:0] hold_next;
  logic [15:0] phase_cnt;
  logic [15:0] phase_next;

  logic        auto_req;
  logic        req_on;
  logic        mismatch;
  logic        switch_go;
  logic        pending;
  logic        hold_active;

  assign wr_en = bus.chipselect & ~bus.write_n;

  // Register file writes; STATUS (address 3) is read-only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      ctrl_src  <= 1'b0;
      ctrl_sw   <= 1'b0;
      hold_cfg  <= 16'd0;
      on_ticks  <= 16'd0;
      off_ticks <= 16'd0;
    end else if (wr_en) begin
      case (bus.address)
        2'd0: begin
          ctrl_en  <= bus.writedata[0];
          ctrl_src <= bus.writedata[1];
          ctrl_sw  <= bus.writedata[2];
        end
        2'd1: hold_cfg <= bus.writedata[15:0];
        2'd2: begin
          on_ticks  <= bus.writedata[15:0];
          off_ticks <= bus.writedata[31:16];
        end
        default: ;
      endcase
    end
  end

  // Free-running tick prescaler, independent of EN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt <= 16'd0;
    end else if (tick) begin
      presc_cnt <= 16'd0;
    end else begin
      presc_cnt <= presc_cnt + 16'd1;
    end
  end

  assign tick = (presc_cnt == TICK_LAST);

  // Auto request: ON_TICKS=0 forces OFF, then OFF_TICKS=0 forces ON,
  // otherwise flip once the phase has reached the current state's budget.
  // Using >= keeps the request asserted while a hold delays the change.
  always_comb begin
    auto_req = 1'b0;
    if (on_ticks == 16'd0) begin
      auto_req = 1'b0;
    end else if (off_ticks == 16'd0) begin
      auto_req = 1'b1;
    end else if (state == ST_ON) begin
      auto_req = (phase_cnt < on_ticks);
    end else begin
      auto_req = (phase_cnt >= off_ticks);
    end
  end

  assign req_on      = ctrl_src ? auto_req : ctrl_sw;
  assign mismatch    = (state != ST_DISABLED) && (req_on != (state == ST_ON));
  assign hold_active = (hold_cnt != 16'd0);
  assign switch_go   = mismatch && !hold_active;
  assign pending     = mismatch && hold_active;

  // Next-state, hold and phase counter logic; decisions use the
  // register values as they stood before this edge's write.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    phase_next = phase_cnt;
    case (state)
      ST_DISABLED: begin
        hold_next  = 16'd0;
        phase_next = 16'd0;
        if (ctrl_en) begin
          state_next = ST_OFF;
        end
      end
      ST_OFF, ST_ON: begin
        if (!ctrl_en) begin
          state_next = ST_DISABLED;
          hold_next  = 16'd0;
          phase_next = 16'd0;
        end else if (switch_go) begin
          state_next = req_on ? ST_ON : ST_OFF;
          hold_next  = hold_cfg;
          phase_next = 16'd0;
        end else if (tick) begin
          if (hold_cnt != 16'd0) begin
            hold_next = hold_cnt - 16'd1;
          end
          if (phase_cnt != 16'hFFFF) begin
            phase_next = phase_cnt + 16'd1;
          end
        end
      end
      default: begin
        state_next = ST_DISABLED;
        hold_next  = 16'd0;
        phase_next = 16'd0;
      end
    endcase
  end

  // State, counters and registered actuator output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_DISABLED;
      hold_cnt  <= 16'd0;
      phase_cnt <= 16'd0;
      out_port  <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      phase_cnt <= phase_next;
      out_port  <= (state_next == ST_ON);
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd0: bus.readdata = {29'd0, ctrl_sw, ctrl_src, ctrl_en};
      2'd1: bus.readdata = {16'd0, hold_cfg};
      2'd2: bus.readdata = {off_ticks, on_ticks};
      2'd3: bus.readdata = {27'd0, hold_active, state, pending, out_port};
      default: bus.readdata = 32'd0;
    endcase
  end

endmodule
